regfile16x16: RTL

- 16-entry × 16-bit general-purpose register file for the single-cycle datapath.
- Feeds the operand-select stage: the 16 register outputs go to two read ports, each built from one mux16_16bit instance.
- One synchronous write port, two combinational read ports, and a flat debug bus for observation.
- R0 is hardwired to zero.

---
 rtl/regfile16x16_pkg.sv | 18 +
 rtl/mux16_16bit.sv | 19 +
 rtl/reg16_en.sv | 28 ++
 rtl/regfile16x16.sv | 94 +++++++++
 4 files changed

// File: rtl/regfile16x16_pkg.sv
// rtl/regfile16x16_pkg.sv - shared sizes and register index names for the register file
//
// Purpose : register-file geometry and symbolic register indices, shared by the
//           register file, the control decoder and the bench.
// Ports   : none (package)
`timescale 1ns/1ps
package regfile16x16_pkg;

  localparam int REG_W      = 16;
  localparam int REG_N      = 16;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [REG_ADDR_W-1:0] {
    R0, R1, R2, R3, R4, R5, R6, R7,
    R8, R9, R10, R11, R12, R13, R14, R15
  } reg_idx_e;

endpackage

// File: rtl/mux16_16bit.sv
// rtl/mux16_16bit.sv - 16-way 16-bit combinational selector
//
// Purpose : read-port selector over the flattened register bank.
// Ports   : sel  - 4-bit word select
//           din  - 16 words flattened, word 0 in [15:0]
//           dout - selected word
`timescale 1ns/1ps
module mux16_16bit
  import regfile16x16_pkg::*;
(
  input  logic [REG_ADDR_W-1:0]  sel,
  input  logic [REG_N*REG_W-1:0] din,
  output logic [REG_W-1:0]       dout
);

  // {sel, 4'b0} is sel*16, the bit offset of the selected word.
  assign dout = din[{sel, 4'b0000} +: REG_W];

endmodule

// File: rtl/reg16_en.sv
// rtl/reg16_en.sv - 16-bit register with asynchronous active-low clear and load enable
//
// Purpose : one storage word of the register file.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low clear
//           en    - load enable
//           d     - load data
//           q     - stored value
`timescale 1ns/1ps
module reg16_en
  import regfile16x16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [REG_W-1:0] d,
  output logic [REG_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile16x16.sv
// rtl/regfile16x16.sv - 16x16 register file, one write port, two combinational read ports
//
// Purpose : general-purpose registers for the single-cycle datapath.
// Ports   : clk      - rising-edge clock
//           rst_n    - asynchronous active-low reset, clears all registers and wr_ack
//           we       - write enable
//           waddr    - write register index
//           wdata    - write data
//           raddr_a  - read port A index
//           raddr_b  - read port B index
//           rdata_a  - read port A data (combinational)
//           rdata_b  - read port B data (combinational)
//           wr_ack   - one-cycle pulse per committed write
//           dbg_regs - all registers flattened, R0 in [15:0], R15 in [255:240]
`timescale 1ns/1ps
module regfile16x16
  import regfile16x16_pkg::*;
#(
  parameter int WIDTH    = REG_W,
  parameter int DEPTH    = REG_N,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [REG_ADDR_W-1:0]  waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0]  raddr_a,
  input  logic [REG_ADDR_W-1:0]  raddr_b,
  output logic [WIDTH-1:0]       rdata_a,
  output logic [WIDTH-1:0]       rdata_b,
  output logic                   wr_ack,
  output logic [DEPTH*WIDTH-1:0] dbg_regs
);

  logic [DEPTH-1:0] we_vec;

  // Write-enable decode. An unknown we or waddr matches no item, so the
  // default path leaves every enable low and no register is disturbed.
  always_comb begin
    we_vec = '0;
    case (we)
      1'b1: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (waddr == REG_ADDR_W'(i)) begin
            we_vec[i] = 1'b1;
          end
        end
      end
      default: we_vec = '0;
    endcase
    if (ZERO_REG != 0) begin
      we_vec[0] = 1'b0;
    end
  end

  // Any surviving enable is a committed write; a discarded R0 write is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= |we_vec;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    if (g == 0 && ZERO_REG != 0) begin : g_zero
      assign dbg_regs[g*WIDTH +: WIDTH] = '0;
    end else begin : g_store
      reg16_en u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (we_vec[g]),
        .d     (wdata),
        .q     (dbg_regs[g*WIDTH +: WIDTH])
      );
    end
  end

  // No write bypass: a read of the register being written shows the old
  // value until the edge, which the single-cycle datapath depends on.
  mux16_16bit u_mux_a (
    .sel  (raddr_a),
    .din  (dbg_regs),
    .dout (rdata_a)
  );

  mux16_16bit u_mux_b (
    .sel  (raddr_b),
    .din  (dbg_regs),
    .dout (rdata_b)
  );

endmodule
